me_search_engine: RTL and testbench

- Parametrised full-search block-matching motion estimator.
- Computes the SAD between one BLK x BLK reference block and every candidate position in a ±RANGE search window, then reports the best SAD and its motion vector.
- Sits between the reference/search ROMs and the downstream vector consumer.
- Adds a start/busy/done handshake, synchronous reset, full-width non-saturating SAD, configurable block and range sizes, and optional early termination.

---
 rtl/me_pkg.sv | 30 +++
 rtl/me_sad_acc.sv | 32 +++
 rtl/me_search_engine.sv | 200 ++++++++++++++++++++
 tb/tb_me_search_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared widths, FSM encoding and constants for the block-matching motion estimator.
package me_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Wide enough for any SAD width; truncate to SAD_W at the point of use.
    localparam logic [63:0] SAD_MAX = '1;

    function automatic int unsigned sad_w(input int unsigned pix_w, input int unsigned blk);
        return pix_w + 2 * $clog2(blk);
    endfunction

    function automatic int unsigned mv_w(input int unsigned range);
        return $clog2(2 * range);
    endfunction

    function automatic int unsigned addr_r_w(input int unsigned blk);
        return 2 * $clog2(blk);
    endfunction

    function automatic int unsigned addr_s_w(input int unsigned stride);
        return 2 * $clog2(stride);
    endfunction

endpackage

// File: rtl/me_sad_acc.sv
// Absolute-difference accumulator: loads on the first pixel of a candidate, adds afterwards.
module me_sad_acc
    import me_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned BLK   = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         valid,
    input  logic                         load,
    input  logic [PIX_W-1:0]             data_r,
    input  logic [PIX_W-1:0]             data_s,
    output logic [sad_w(PIX_W, BLK)-1:0] sum
);
    localparam int unsigned SAD_W = sad_w(PIX_W, BLK);

    logic [PIX_W-1:0] diff;

    always_comb begin
        diff = (data_r >= data_s) ? (data_r - data_s) : (data_s - data_r);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sum <= '0;
        end else if (valid) begin
            sum <= load ? SAD_W'(diff) : (sum + SAD_W'(diff));
        end
    end

endmodule

// File: rtl/me_search_engine.sv
// Full-search block-matching motion estimator with start/busy/done handshake and early termination.
module me_search_engine
    import me_pkg::*;
#(
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned BLK        = 16,
    parameter int unsigned RANGE      = 8,
    parameter int unsigned S_STRIDE   = 32,
    parameter int unsigned EARLY_TERM = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [sad_w(PIX_W, BLK)-1:0]  best_sad,
    output logic [mv_w(RANGE)-1:0]        motion_x,
    output logic [mv_w(RANGE)-1:0]        motion_y,
    output logic [addr_r_w(BLK)-1:0]      addr_r,
    input  logic [PIX_W-1:0]              data_r,
    output logic [addr_s_w(S_STRIDE)-1:0] addr_s,
    input  logic [PIX_W-1:0]              data_s
);
    localparam int unsigned SAD_W = sad_w(PIX_W, BLK);
    localparam int unsigned MV_W  = mv_w(RANGE);
    localparam int unsigned LB    = $clog2(BLK);
    localparam int unsigned LS    = $clog2(S_STRIDE);
    localparam int unsigned P     = 2 * RANGE;
    localparam int unsigned TAG_W = 2 * MV_W;

    state_t state, state_n;
    logic   drain_cnt, drain_cnt_n;

    logic [LB-1:0]   pix_i, pix_j, pix_i_n, pix_j_n;
    logic [MV_W-1:0] cand_x, cand_y, cand_x_n, cand_y_n;
    logic [LS-1:0]   row_n, col_n;

    logic             v_a, first_a, last_a, last_cand;
    logic [TAG_W-1:0] tag_a, tag_b, tag_c;
    logic             v_b, first_b, last_b, v_c, last_c;
    logic             abort_c, commit_c, kill_a, kill_b;

    logic [SAD_W-1:0] sum, best, best_n;
    logic [MV_W-1:0]  best_x, best_y, best_x_n, best_y_n;

    // Stage tags; a candidate's in-flight reads are dropped when it aborts.
    always_comb begin
        v_a       = (state == ST_RUN);
        first_a   = (pix_i == '0) && (pix_j == '0);
        last_a    = (pix_i == LB'(BLK - 1)) && (pix_j == LB'(BLK - 1));
        tag_a     = {cand_y, cand_x};
        last_cand = (cand_x == MV_W'(P - 1)) && (cand_y == MV_W'(P - 1));
        commit_c  = v_c && last_c && (sum < best);
        abort_c   = (EARLY_TERM != 0) && v_c && !last_c && (sum >= best);
        kill_a    = abort_c && v_a && (tag_a == tag_c);
        kill_b    = abort_c && v_b && (tag_b == tag_c);
    end

    always_comb begin
        state_n     = state;
        drain_cnt_n = drain_cnt;
        pix_i_n     = pix_i;
        pix_j_n     = pix_j;
        cand_x_n    = cand_x;
        cand_y_n    = cand_y;
        best_n      = best;
        best_x_n    = best_x;
        best_y_n    = best_y;
        if (commit_c) begin
            best_n   = sum;
            best_x_n = tag_c[MV_W-1:0];
            best_y_n = tag_c[TAG_W-1:MV_W];
        end
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n  = ST_RUN;
                    pix_i_n  = '0;
                    pix_j_n  = '0;
                    cand_x_n = '0;
                    cand_y_n = '0;
                    best_n   = SAD_W'(SAD_MAX);
                    best_x_n = '0;
                    best_y_n = '0;
                end
            end
            ST_RUN: begin
                // Advance to the next candidate at its end or when it has been abandoned.
                if (last_a || kill_a) begin
                    pix_i_n = '0;
                    pix_j_n = '0;
                    if (last_cand) begin
                        state_n     = ST_DRAIN;
                        drain_cnt_n = 1'b0;
                        cand_x_n    = '0;
                        cand_y_n    = '0;
                    end else if (cand_x == MV_W'(P - 1)) begin
                        cand_x_n = '0;
                        cand_y_n = cand_y + 1'b1;
                    end else begin
                        cand_x_n = cand_x + 1'b1;
                    end
                end else if (pix_j == LB'(BLK - 1)) begin
                    pix_j_n = '0;
                    pix_i_n = pix_i + 1'b1;
                end else begin
                    pix_j_n = pix_j + 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_cnt_n = 1'b1;
                if (drain_cnt) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        row_n = LS'(pix_i_n) + LS'(cand_y_n);
        col_n = LS'(pix_j_n) + LS'(cand_x_n);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_cnt_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_i    <= '0;
            pix_j    <= '0;
            cand_x   <= '0;
            cand_y   <= '0;
            addr_s   <= '0;
            v_b      <= 1'b0;
            first_b  <= 1'b0;
            last_b   <= 1'b0;
            tag_b    <= '0;
            v_c      <= 1'b0;
            last_c   <= 1'b0;
            tag_c    <= '0;
            best     <= SAD_W'(SAD_MAX);
            best_x   <= '0;
            best_y   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            best_sad <= SAD_W'(SAD_MAX);
            motion_x <= '0;
            motion_y <= '0;
        end else begin
            pix_i   <= pix_i_n;
            pix_j   <= pix_j_n;
            cand_x  <= cand_x_n;
            cand_y  <= cand_y_n;
            addr_s  <= {row_n, col_n};
            v_b     <= v_a && !kill_a;
            first_b <= first_a;
            last_b  <= last_a;
            tag_b   <= tag_a;
            v_c     <= v_b && !kill_b;
            last_c  <= last_b;
            tag_c   <= tag_b;
            best    <= best_n;
            best_x  <= best_x_n;
            best_y  <= best_y_n;
            busy    <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
            done    <= (state_n == ST_DONE);
            if (state_n == ST_DONE) begin
                best_sad <= best_n;
                motion_x <= best_x_n - MV_W'(RANGE);
                motion_y <= best_y_n - MV_W'(RANGE);
            end
        end
    end

    assign addr_r = {pix_i, pix_j};

    me_sad_acc #(
        .PIX_W (PIX_W),
        .BLK   (BLK)
    ) u_acc (
        .clock  (clock),
        .reset  (reset),
        .valid  (v_b && !kill_b),
        .load   (first_b),
        .data_r (data_r),
        .data_s (data_s),
        .sum    (sum)
    );

endmodule

// File: tb/tb_me_search_engine.sv
// Randomized bench: two engines (plain and early-terminating) against a full-search reference model.
module tb_me_search_engine;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned BLK      = 4;
    localparam int unsigned RANGE    = 4;
    localparam int unsigned S_STRIDE = 16;
    localparam int unsigned SAD_W    = 12;
    localparam int unsigned MV_W     = 3;
    localparam int unsigned AR_W     = 4;
    localparam int unsigned AS_W     = 8;
    localparam int B       = 4;
    localparam int R       = 4;
    localparam int SS      = 16;
    localparam int LAT     = (2 * R) * (2 * R) * B * B + 3;
    localparam int TIMEOUT = 4000;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy0, done0, busy1, done1;
    logic [SAD_W-1:0] sad0, sad1;
    logic [MV_W-1:0]  mx0, my0, mx1, my1;
    logic [AR_W-1:0]  ar0, ar1;
    logic [AS_W-1:0]  as0, as1;
    logic [PIX_W-1:0] dr0, ds0, dr1, ds1;

    logic [7:0] ref_mem  [B*B];
    logic [7:0] srch_mem [SS*SS];

    int tests = 0;
    int fails = 0;
    int lat0, lat1, bcnt0, pulses0, pulses1;

    always #5 clk = ~clk;

    me_search_engine #(.PIX_W(PIX_W), .BLK(BLK), .RANGE(RANGE), .S_STRIDE(S_STRIDE), .EARLY_TERM(0)) dut0 (
        .clock(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
        .best_sad(sad0), .motion_x(mx0), .motion_y(my0),
        .addr_r(ar0), .data_r(dr0), .addr_s(as0), .data_s(ds0)
    );

    me_search_engine #(.PIX_W(PIX_W), .BLK(BLK), .RANGE(RANGE), .S_STRIDE(S_STRIDE), .EARLY_TERM(1)) dut1 (
        .clock(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
        .best_sad(sad1), .motion_x(mx1), .motion_y(my1),
        .addr_r(ar1), .data_r(dr1), .addr_s(as1), .data_s(ds1)
    );

    // Memories with one cycle of read latency
    always @(posedge clk) begin
        dr0 <= ref_mem[ar0];
        ds0 <= srch_mem[as0];
        dr1 <= ref_mem[ar1];
        ds1 <= srch_mem[as1];
    end

    task automatic model(output logic [SAD_W+2*MV_W-1:0] exp_v);
        int s, d, bsad, bdx, bdy;
        bsad = 32'h7fffffff;
        bdx  = 0;
        bdy  = 0;
        for (int dy = -R; dy < R; dy++) begin
            for (int dx = -R; dx < R; dx++) begin
                s = 0;
                for (int i = 0; i < B; i++) begin
                    for (int j = 0; j < B; j++) begin
                        d = int'(ref_mem[i*B + j]) - int'(srch_mem[(i + dy + R) * SS + (j + dx + R)]);
                        s += (d < 0) ? -d : d;
                    end
                end
                if (s < bsad) begin
                    bsad = s;
                    bdx  = dx;
                    bdy  = dy;
                end
            end
        end
        exp_v = {SAD_W'(bsad), MV_W'(bdx), MV_W'(bdy)};
    endtask

    task automatic fill_exact(input int cx, input int cy);
        for (int k = 0; k < B*B; k++) ref_mem[k] = 8'($urandom_range(0, 127));
        for (int k = 0; k < SS*SS; k++) srch_mem[k] = 8'($urandom_range(128, 255));
        for (int i = 0; i < B; i++)
            for (int j = 0; j < B; j++)
                srch_mem[(i + cy + R) * SS + (j + cx + R)] = ref_mem[i*B + j];
    endtask

    task automatic run_search(input bit hold);
        bit seen0, seen1;
        int cyc;
        lat0 = -1; lat1 = -1; bcnt0 = 0; pulses0 = 0; pulses1 = 0;
        seen0 = 1'b0; seen1 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        cyc = 1;
        while (!(seen0 && seen1) && cyc <= TIMEOUT) begin
            if (busy0 && !seen0) bcnt0++;
            if (done0) begin pulses0++; if (!seen0) lat0 = cyc; seen0 = 1'b1; end
            if (done1 && !seen1) begin pulses1++; lat1 = cyc; seen1 = 1'b1; end
            if (!(seen0 && seen1)) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!(seen0 && seen1)) begin
            tests++; fails++;
            $display("FAIL search_timeout: done0=%0b done1=%0b seen after %0d cycles, required both", seen0, seen1, cyc);
        end
        if (!hold) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                if (done0) pulses0++;
                if (done1) pulses1++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy0); end
        tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done0); end
        tests++; if (sad0 !== 12'hFFF) begin fails++; $display("FAIL reset_sad: got %h want fff", sad0); end
        tests++; if ({mx0, my0} !== 6'h00) begin fails++; $display("FAIL reset_mv: got %h/%h want 0/0", mx0, my0); end
        tests++; if ({ar0, as0} !== 12'h000) begin fails++; $display("FAIL reset_addr: got %h/%h want 0/0", ar0, as0); end
        tests++;
        if ({busy1, done1, sad1, mx1, my1, ar1, as1} !== {2'b00, 12'hFFF, 6'h00, 12'h000}) begin
            fails++; $display("FAIL reset_et: got busy=%b done=%b sad=%h mv=%h/%h want 0 0 fff 0/0", busy1, done1, sad1, mx1, my1);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_exact_match();
        logic [SAD_W+2*MV_W-1:0] exp_v;
        fill_exact(3, -2);
        model(exp_v);
        run_search(1'b0);
        tests++; if ({sad0, mx0, my0} !== exp_v) begin fails++; $display("FAIL exact_result0: got %h want %h", {sad0, mx0, my0}, exp_v); end
        tests++; if ({sad1, mx1, my1} !== exp_v) begin fails++; $display("FAIL exact_result1: got %h want %h", {sad1, mx1, my1}, exp_v); end
        tests++; if (lat0 !== LAT) begin fails++; $display("FAIL exact_latency0: got %0d want %0d", lat0, LAT); end
        tests++; if (bcnt0 !== LAT - 1) begin fails++; $display("FAIL exact_busy_cycles: got %0d want %0d", bcnt0, LAT - 1); end
        tests++; if (!(lat1 > 0 && lat1 < LAT)) begin fails++; $display("FAIL exact_latency1: got %0d want below %0d", lat1, LAT); end
        tests++; if (pulses0 !== 1 || pulses1 !== 1) begin fails++; $display("FAIL exact_pulses: got %0d/%0d want 1/1", pulses0, pulses1); end
    endtask

    task automatic test_uniform();
        logic [SAD_W+2*MV_W-1:0] exp_v;
        for (int k = 0; k < B*B; k++) ref_mem[k] = 8'h80;
        for (int k = 0; k < SS*SS; k++) srch_mem[k] = 8'h80;
        model(exp_v);
        run_search(1'b0);
        tests++; if ({sad0, mx0, my0} !== exp_v) begin fails++; $display("FAIL uniform_result0: got %h want %h", {sad0, mx0, my0}, exp_v); end
        tests++; if ({sad1, mx1, my1} !== exp_v) begin fails++; $display("FAIL uniform_result1: got %h want %h", {sad1, mx1, my1}, exp_v); end
        tests++; if (lat0 !== LAT) begin fails++; $display("FAIL uniform_latency0: got %0d want %0d", lat0, LAT); end
    endtask

    task automatic test_max_sad();
        logic [SAD_W+2*MV_W-1:0] exp_v;
        for (int k = 0; k < B*B; k++) ref_mem[k] = 8'hFF;
        for (int k = 0; k < SS*SS; k++) srch_mem[k] = 8'h00;
        model(exp_v);
        run_search(1'b0);
        tests++; if ({sad0, mx0, my0} !== exp_v) begin fails++; $display("FAIL max_result0: got %h want %h", {sad0, mx0, my0}, exp_v); end
        tests++; if ({sad1, mx1, my1} !== exp_v) begin fails++; $display("FAIL max_result1: got %h want %h", {sad1, mx1, my1}, exp_v); end
        tests++; if (!(lat1 > 0 && lat1 <= LAT)) begin fails++; $display("FAIL max_latency1: got %0d want at most %0d", lat1, LAT); end
    endtask

    task automatic test_random();
        logic [SAD_W+2*MV_W-1:0] exp_v;
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < B*B; k++) ref_mem[k] = 8'($urandom);
            for (int k = 0; k < SS*SS; k++) srch_mem[k] = 8'($urandom);
            model(exp_v);
            run_search(1'b0);
            tests++; if ({sad0, mx0, my0} !== exp_v) begin fails++; $display("FAIL random%0d_result0: got %h want %h", n, {sad0, mx0, my0}, exp_v); end
            tests++; if ({sad1, mx1, my1} !== exp_v) begin fails++; $display("FAIL random%0d_result1: got %h want %h", n, {sad1, mx1, my1}, exp_v); end
            tests++; if (!(lat1 > 0 && lat1 <= LAT)) begin fails++; $display("FAIL random%0d_latency1: got %0d want at most %0d", n, lat1, LAT); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [SAD_W+2*MV_W-1:0] exp_v;
        fill_exact(-1, 2);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (600) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({busy0, sad0, mx0, my0} !== {1'b0, 12'hFFF, 6'h00}) begin
            fails++; $display("FAIL midreset_state0: got busy=%b sad=%h mv=%h/%h want 0 fff 0/0", busy0, sad0, mx0, my0);
        end
        tests++;
        if ({busy1, sad1, mx1, my1} !== {1'b0, 12'hFFF, 6'h00}) begin
            fails++; $display("FAIL midreset_state1: got busy=%b sad=%h mv=%h/%h want 0 fff 0/0", busy1, sad1, mx1, my1);
        end
        @(negedge clk);
        reset = 1'b0;
        fill_exact(3, -2);
        model(exp_v);
        run_search(1'b0);
        tests++; if ({sad0, mx0, my0} !== exp_v) begin fails++; $display("FAIL midreset_result0: got %h want %h", {sad0, mx0, my0}, exp_v); end
        tests++; if ({sad1, mx1, my1} !== exp_v) begin fails++; $display("FAIL midreset_result1: got %h want %h", {sad1, mx1, my1}, exp_v); end
    endtask

    task automatic test_handshake();
        logic [SAD_W+2*MV_W-1:0] exp_v, held;
        int unstable, cyc;
        bit got_done;
        fill_exact(-3, 1);
        model(exp_v);
        run_search(1'b1);
        held = {sad0, mx0, my0};
        tests++; if (lat0 !== LAT || pulses0 !== 1) begin fails++; $display("FAIL hold_no_restart: latency %0d pulses %0d want %0d and 1", lat0, pulses0, LAT); end
        tests++; if (held !== exp_v) begin fails++; $display("FAIL hold_result: got %h want %h", held, exp_v); end
        @(posedge clk);
        #1;
        tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL hold_idle_gap: busy got %b want 0", busy0); end
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL hold_restart: busy got %b want 1", busy0); end
        unstable = 0;
        got_done = 1'b0;
        cyc = 0;
        while (!got_done && cyc < TIMEOUT) begin
            if ({sad0, mx0, my0} !== held) unstable++;
            @(posedge clk);
            #1;
            cyc++;
            got_done = done0;
        end
        tests++; if (unstable !== 0 || !got_done) begin fails++; $display("FAIL hold_stable: changes %0d done %b want 0 and 1", unstable, got_done); end
        tests++; if ({sad0, mx0, my0} !== exp_v) begin fails++; $display("FAIL second_result: got %h want %h", {sad0, mx0, my0}, exp_v); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_exact_match();
        test_uniform();
        test_max_sad();
        test_random();
        test_reset_mid_run();
        test_handshake();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
